// File: rtl/vga_text_grid_renderer.sv
// VGA timing generator with a COLS x ROWS font-glyph text grid, runtime scaling and row highlight.
// Optional blinking cursor when VGA_TEXT_CURSOR_EN is defined.
module vga_text_grid_renderer #(
    parameter int H_RES  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_RES  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    parameter int FONT_W = 8,
    parameter int FONT_H = 16,
    parameter int COLS   = 40,
    parameter int ROWS   = 20,
    parameter int CHAR_W = 7,
    parameter int RGB_W  = 3,
    parameter int TXT_AW = $clog2(COLS*ROWS),
    parameter int ROM_AW = CHAR_W + $clog2(FONT_H)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        scale_x,
    input  logic [3:0]        scale_y,
    input  logic [RGB_W-1:0]  col_fg,
    input  logic [RGB_W-1:0]  col_bg,
    input  logic [RGB_W-1:0]  col_sel_fg,
    input  logic [RGB_W-1:0]  col_sel_bg,
    input  logic [7:0]        sel_row,
`ifdef VGA_TEXT_CURSOR_EN
    input  logic [7:0]        cursor_col,
    input  logic [7:0]        cursor_row,
`endif
    output logic [TXT_AW-1:0] txt_addr,
    input  logic [CHAR_W-1:0] txt_q,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [FONT_W-1:0] rom_q,
    output logic [RGB_W-1:0]  rgb,
    output logic              hsync,
    output logic              vsync,
    output logic              frame_start
);

    localparam int H_TOT = H_RES + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_RES + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int FCW   = $clog2(FONT_W + 1);
    localparam int FLW   = $clog2(FONT_H + 1);
    localparam int FLA   = $clog2(FONT_H);
    localparam int CCW   = $clog2(COLS + 1);
    localparam int CRW   = $clog2(ROWS + 1);

    localparam logic [HW-1:0]     H_LAST   = HW'(H_TOT - 1);
    localparam logic [HW-1:0]     H_RES_C  = HW'(H_RES);
    localparam logic [HW-1:0]     HS_BEG   = HW'(H_RES + H_FP);
    localparam logic [HW-1:0]     HS_END   = HW'(H_RES + H_FP + H_SYNC);
    localparam logic [VW-1:0]     V_LAST   = VW'(V_TOT - 1);
    localparam logic [VW-1:0]     V_RES_C  = VW'(V_RES);
    localparam logic [VW-1:0]     VS_BEG   = VW'(V_RES + V_FP);
    localparam logic [VW-1:0]     VS_END   = VW'(V_RES + V_FP + V_SYNC);
    localparam logic [FCW-1:0]    FW_C     = FCW'(FONT_W);
    localparam logic [FLW-1:0]    FH_C     = FLW'(FONT_H);
    localparam logic [CCW-1:0]    COLS_C   = CCW'(COLS);
    localparam logic [CCW-1:0]    COL_LAST = CCW'(COLS - 1);
    localparam logic [CRW-1:0]    ROWS_C   = CRW'(ROWS);
    localparam logic [CRW-1:0]    ROW_LAST = CRW'(ROWS - 1);
    localparam logic [TXT_AW-1:0] COLS_A   = TXT_AW'(COLS);

    typedef struct packed {
        logic           act;
        logic           hs;
        logic           vs;
        logic           fs;
        logic           grid;
        logic           sel;
        logic           cur;
        logic [FCW-1:0] fcol;
        logic [FLW-1:0] fline;
    } stage_t;

    logic [HW-1:0]     h;
    logic [VW-1:0]     v;
    logic [3:0]        sx_cnt, sy_cnt, sx_r, sy_r;
    logic [FCW-1:0]    fcol;
    logic [FLW-1:0]    fline;
    logic [CCW-1:0]    ccol;
    logic [CRW-1:0]    crow;
    logic [TXT_AW-1:0] addr_cur, row_base;

    logic [3:0]        sx_in, sy_in, sx_eff;
    logic              at_origin, line_end, frame_end, x_tick, y_tick, row_wrap, in_grid0, cur0;
    logic [TXT_AW-1:0] row_base_nx;
    stage_t            s0, s1, s2, s3;

    always_comb begin
        sx_in       = (scale_x == 4'd0) ? 4'd1 : scale_x;
        sy_in       = (scale_y == 4'd0) ? 4'd1 : scale_y;
        at_origin   = (h == '0) && (v == '0);
        // The frame-start pixel already uses the freshly sampled horizontal scale.
        sx_eff      = at_origin ? sx_in : sx_r;
        line_end    = (h == H_LAST);
        frame_end   = line_end && (v == V_LAST);
        x_tick      = (sx_cnt == sx_eff - 4'd1);
        y_tick      = (sy_cnt == sy_r - 4'd1);
        row_wrap    = y_tick && (fline == FH_C);
        row_base_nx = (row_wrap && crow < ROW_LAST) ? row_base + COLS_A : row_base;
        in_grid0    = (ccol < COLS_C) && (crow < ROWS_C);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h        <= '0;
            v        <= '0;
            sx_cnt   <= '0;
            sy_cnt   <= '0;
            sx_r     <= 4'd1;
            sy_r     <= 4'd1;
            fcol     <= '0;
            fline    <= '0;
            ccol     <= '0;
            crow     <= '0;
            addr_cur <= '0;
            row_base <= '0;
        end else begin
            if (at_origin) begin
                sx_r <= sx_in;
                sy_r <= sy_in;
            end
            if (frame_end) begin
                h        <= '0;
                v        <= '0;
                sx_cnt   <= '0;
                sy_cnt   <= '0;
                fcol     <= '0;
                fline    <= '0;
                ccol     <= '0;
                crow     <= '0;
                addr_cur <= '0;
                row_base <= '0;
            end else if (line_end) begin
                h        <= '0;
                v        <= v + 1'b1;
                sx_cnt   <= '0;
                fcol     <= '0;
                ccol     <= '0;
                addr_cur <= row_base_nx;
                row_base <= row_base_nx;
                if (y_tick) begin
                    sy_cnt <= '0;
                    if (fline == FH_C) begin
                        fline <= '0;
                        if (crow < ROWS_C)
                            crow <= crow + 1'b1;
                    end else begin
                        fline <= fline + 1'b1;
                    end
                end else begin
                    sy_cnt <= sy_cnt + 1'b1;
                end
            end else begin
                h <= h + 1'b1;
                if (x_tick) begin
                    sx_cnt <= '0;
                    if (fcol == FW_C) begin
                        fcol <= '0;
                        if (ccol < COLS_C)
                            ccol <= ccol + 1'b1;
                        if (ccol < COL_LAST)
                            addr_cur <= addr_cur + 1'b1;
                    end else begin
                        fcol <= fcol + 1'b1;
                    end
                end else begin
                    sx_cnt <= sx_cnt + 1'b1;
                end
            end
        end
    end

`ifdef VGA_TEXT_CURSOR_EN
    logic [4:0] frame_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            frame_cnt <= '0;
        else if (frame_end)
            frame_cnt <= frame_cnt + 1'b1;
    end

    assign cur0 = in_grid0 && frame_cnt[4] &&
                  (8'(ccol) == cursor_col) && (8'(crow) == cursor_row);
`else
    assign cur0 = 1'b0;
`endif

    always_comb begin
        s0       = '0;
        s0.act   = (h < H_RES_C) && (v < V_RES_C);
        s0.hs    = (h >= HS_BEG) && (h < HS_END);
        s0.vs    = (v >= VS_BEG) && (v < VS_END);
        s0.fs    = at_origin;
        s0.grid  = in_grid0;
        s0.sel   = in_grid0 && (fline < FH_C) && (8'(crow) == sel_row);
        s0.cur   = cur0;
        s0.fcol  = fcol;
        s0.fline = fline;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txt_addr <= '0;
            s1       <= '0;
            s2       <= '0;
            s3       <= '0;
        end else begin
            if (in_grid0)
                txt_addr <= addr_cur;
            s1 <= s0;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // The ROM address is formed from the RAM output directly so the ROM read fits in S2.
    assign rom_addr = s2.grid ? ROM_AW'({s2.fline[FLA-1:0], txt_q}) : '0;

    logic [FONT_W-1:0] glyph_sh;
    logic              glyph_on;
    logic [RGB_W-1:0]  fg_c, bg_c, pix, rgb_nx;

    always_comb begin
        fg_c     = s3.sel ? col_sel_fg : col_fg;
        bg_c     = s3.sel ? col_sel_bg : col_bg;
        glyph_sh = rom_q << s3.fcol;
        glyph_on = s3.grid && (s3.fcol < FW_C) && (s3.fline < FH_C) && glyph_sh[FONT_W-1];
        pix      = (glyph_on ^ s3.cur) ? fg_c : bg_c;
        rgb_nx   = s3.act ? pix : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb         <= '0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            rgb         <= rgb_nx;
            hsync       <= s3.hs;
            vsync       <= s3.vs;
            frame_start <= s3.fs;
        end
    end

endmodule
